// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-cold column strobe, frame-level ghost rejection, press/release debounce
// and a valid/ack event port. Define KEYPAD_REPEAT_EN to build the auto-repeat frame counter.
module keypad_scanner #(
   parameter int ROWS          = 4,
   parameter int COLS          = 4,
   parameter int SCAN_DIV      = 1024,
   parameter int DEBOUNCE      = 3,
   parameter int REPEAT_FRAMES = 32,
   localparam int KW = ($clog2(ROWS*COLS) > 1) ? $clog2(ROWS*COLS) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] row,
   output logic [COLS-1:0] col,
   output logic [KW-1:0]   key_code,
   output logic            key_valid,
   input  logic            key_ack,
   output logic            key_held,
   output logic            overrun
);

   localparam int RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;
   localparam int CW = ($clog2(COLS) > 1) ? $clog2(COLS) : 1;
   localparam int DW = ($clog2(SCAN_DIV) > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_t;

   logic          started;
   logic [CW-1:0] col_idx;
   logic [DW-1:0] div_cnt;
   logic          sample;
   logic          last_col;
   logic          frame_end;

   logic [1:0]    samp_cnt;
   logic [RW-1:0] samp_row;
   logic [KW-1:0] samp_key;

   logic          acc_any;
   logic          acc_multi;
   logic [KW-1:0] acc_key;
   logic          cur_any;
   logic          cur_multi;
   logic [KW-1:0] cur_key;
   logic          res_none;
   logic          res_single;
   logic          match;

   state_t        state;
   logic [3:0]    cnt;
   logic [KW-1:0] cand;
   logic          press_done;
   logic          release_done;
   logic          rep_hit;
   logic          emit_req;

   assign sample    = started && (div_cnt == DW'(SCAN_DIV - 1));
   assign last_col  = (col_idx == CW'(COLS - 1));
   assign frame_end = sample && last_col;

   // The strobe stays all-ones in reset and starts on column 0 at the first edge afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         started <= 1'b0;
         col_idx <= '0;
         div_cnt <= '0;
         col     <= '1;
      end else if (!started) begin
         started <= 1'b1;
         col     <= ~(COLS'(1));
      end else if (sample) begin
         div_cnt <= '0;
         if (last_col) begin
            col_idx <= '0;
            col     <= ~(COLS'(1));
         end else begin
            col_idx <= col_idx + CW'(1);
            col     <= ~(COLS'(1) << (col_idx + CW'(1)));
         end
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

   // Count low rows in this column sample, saturating at two, and remember the first one.
   always_comb begin
      samp_cnt = 2'd0;
      samp_row = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (!row[r]) begin
            if (samp_cnt == 2'd0) samp_row = RW'(r);
            if (samp_cnt != 2'd2) samp_cnt = samp_cnt + 2'd1;
         end
      end
   end

   assign samp_key   = KW'(int'(samp_row) * COLS + int'(col_idx));
   assign cur_any    = acc_any || (samp_cnt != 2'd0);
   assign cur_multi  = acc_multi || (samp_cnt == 2'd2) || (acc_any && (samp_cnt != 2'd0));
   assign cur_key    = acc_any ? acc_key : samp_key;
   assign res_none   = !cur_any;
   assign res_single = cur_any && !cur_multi;
   assign match      = res_single && (cur_key == cand);

   // Frame accumulator; the last column's sample is folded in combinationally at frame end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_any   <= 1'b0;
         acc_multi <= 1'b0;
         acc_key   <= '0;
      end else if (sample) begin
         if (last_col) begin
            acc_any   <= 1'b0;
            acc_multi <= 1'b0;
            acc_key   <= '0;
         end else begin
            acc_any   <= cur_any;
            acc_multi <= cur_multi;
            acc_key   <= cur_key;
         end
      end
   end

   assign press_done   = ((state == ST_IDLE) && res_single && (DEBOUNCE == 1)) ||
                         ((state == ST_DEBOUNCE) && match && (cnt == 4'(DEBOUNCE - 1)));
   assign release_done = ((state == ST_PRESSED) && res_none && (DEBOUNCE == 1)) ||
                         ((state == ST_RELEASE) && res_none && (cnt == 4'(DEBOUNCE - 1)));
   assign emit_req     = frame_end && (press_done || rep_hit);

`ifdef KEYPAD_REPEAT_EN
   localparam int RPW = ($clog2(REPEAT_FRAMES + 1) > 1) ? $clog2(REPEAT_FRAMES + 1) : 1;

   logic [RPW-1:0] rep_cnt;

   assign rep_hit = (state == ST_PRESSED) && match && (rep_cnt == RPW'(REPEAT_FRAMES - 1));

   // Counts consecutive SINGLE(cand) frames while pressed; any other frame or state restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt <= '0;
      end else if (frame_end) begin
         if ((state != ST_PRESSED) || !match || rep_hit) rep_cnt <= '0;
         else                                            rep_cnt <= rep_cnt + RPW'(1);
      end
   end
`else
   localparam int unused_repeat_frames = REPEAT_FRAMES;

   assign rep_hit = 1'b0;
`endif

   // Debounce FSM plus the event port: a new event may replace a pending one only if acked this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         cand      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (emit_req) begin
            if (!key_valid || key_ack) begin
               key_code  <= cur_key;
               key_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (key_valid && key_ack) begin
            key_valid <= 1'b0;
         end

         if (frame_end) begin
            case (state)
               ST_IDLE: begin
                  if (res_single) begin
                     cand <= cur_key;
                     cnt  <= 4'd1;
                     if (press_done) begin
                        state    <= ST_PRESSED;
                        key_held <= 1'b1;
                     end else begin
                        state <= ST_DEBOUNCE;
                     end
                  end
               end
               ST_DEBOUNCE: begin
                  if (match) begin
                     cnt <= cnt + 4'd1;
                     if (press_done) begin
                        state    <= ST_PRESSED;
                        key_held <= 1'b1;
                     end
                  end else begin
                     state <= ST_IDLE;
                     cnt   <= 4'd0;
                  end
               end
               ST_PRESSED: begin
                  if (res_none) begin
                     cnt <= 4'd1;
                     if (release_done) begin
                        state    <= ST_IDLE;
                        key_held <= 1'b0;
                     end else begin
                        state <= ST_RELEASE;
                     end
                  end
               end
               ST_RELEASE: begin
                  if (res_none) begin
                     cnt <= cnt + 4'd1;
                     if (release_done) begin
                        state    <= ST_IDLE;
                        key_held <= 1'b0;
                        cnt      <= 4'd0;
                     end
                  end else begin
                     state <= ST_PRESSED;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 keypad model (SCAN_DIV=4, DEBOUNCE=3, 16-clock frames).
module tb_keypad_scanner;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;
   localparam int REPEAT_FRAMES = 4;
   localparam int FRAME = COLS * SCAN_DIV;

   logic            clk = 1'b0;
   logic            rst;
   logic [ROWS-1:0] row;
   logic [COLS-1:0] col;
   logic [3:0]      key_code;
   logic            key_valid;
   logic            key_ack;
   logic            key_held;
   logic            overrun;
   logic [15:0]     pressed;

   int   checks = 0;
   int   failures = 0;
   int   ev_count = 0;
   int   ovr_count = 0;
   logic prev_valid = 1'b0;

   keypad_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE(DEBOUNCE), .REPEAT_FRAMES(REPEAT_FRAMES)
   ) dut (
      .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
      .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Keypad model: a pressed key pulls its row low while its column is strobed.
   always_comb begin
      row = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (pressed[r*COLS+c] && !col[c]) row[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid === 1'b1 && prev_valid !== 1'b1) ev_count <= ev_count + 1;
      if (overrun === 1'b1) ovr_count <= ovr_count + 1;
      prev_valid <= key_valid;
   end

   task automatic wait_clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sync_frame;
      logic [3:0] prev;
      bit found;
      prev = col;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (prev == 4'b0111 && col == 4'b1110) found = 1'b1;
         prev = col;
      end
      checks++;
      if (!found) begin failures++; $display("[TB] FAIL sync_frame: got col=%b required frame start", col); end
   endtask

   task automatic wait_valid(input int limit, output int waited);
      waited = 0;
      while (key_valid !== 1'b1 && waited < limit) begin
         @(negedge clk);
         waited++;
      end
   endtask

   task automatic test_reset;
      logic [3:0] exp_col;
      rst = 1'b1; key_ack = 1'b0; pressed = '0;
      wait_clocks(5);
      checks++;
      if (col !== 4'hF) begin failures++; $display("[TB] FAIL reset_col: got %b required 1111", col); end
      checks++;
      if ({key_code, key_valid, key_held, overrun} !== 7'd0) begin
         failures++; $display("[TB] FAIL reset_outputs: got code=%0d v=%b h=%b o=%b required 0", key_code, key_valid, key_held, overrun);
      end
      rst = 1'b0;
      checks++;
      if (col !== 4'hF) begin failures++; $display("[TB] FAIL reset_release_col: got %b required 1111", col); end
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         exp_col = ~(4'b0001 << (((k - 1) / 4) % 4));
         checks++;
         if (col !== exp_col) begin failures++; $display("[TB] FAIL scan_col[%0d]: got %b required %b", k, col, exp_col); end
         checks++;
         if ({key_code, key_valid, key_held, overrun} !== 7'd0) begin
            failures++; $display("[TB] FAIL scan_idle[%0d]: got code=%0d v=%b h=%b o=%b required 0", k, key_code, key_valid, key_held, overrun);
         end
      end
   endtask

   task automatic test_clean_press;
      int waited, vhi, ev0;
      sync_frame;
      ev0 = ev_count;
      pressed = 16'h0200;
      wait_valid(60, waited);
      checks++;
      if (waited != 48) begin failures++; $display("[TB] FAIL clean_latency: got %0d required 48", waited); end
      checks++;
      if (key_code !== 4'd9) begin failures++; $display("[TB] FAIL clean_code: got %0d required 9", key_code); end
      checks++;
      if (key_held !== 1'b1) begin failures++; $display("[TB] FAIL clean_held: got %b required 1", key_held); end
      vhi = 1;
      @(negedge clk); if (key_valid === 1'b1) vhi++;
      @(negedge clk); if (key_valid === 1'b1) vhi++;
      key_ack = 1'b1;
      @(negedge clk); if (key_valid === 1'b1) vhi++;
      key_ack = 1'b0;
      checks++;
      if (vhi != 3) begin failures++; $display("[TB] FAIL clean_valid_width: got %0d required 3", vhi); end
      wait_clocks(45);
      checks++;
      if (key_held !== 1'b1 || ev_count != ev0 + 1) begin
         failures++; $display("[TB] FAIL clean_hold: got held=%b events=%0d required 1 and %0d", key_held, ev_count - ev0, 1);
      end
      pressed = '0;
      wait_clocks(47);
      checks++;
      if (key_held !== 1'b1) begin failures++; $display("[TB] FAIL clean_held_before_release: got %b required 1", key_held); end
      wait_clocks(1);
      checks++;
      if (key_held !== 1'b0 || key_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL clean_release: got held=%b valid=%b required 0 0", key_held, key_valid);
      end
   endtask

   task automatic test_bounce;
      int waited, ev0;
      bit pattern [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      sync_frame;
      ev0 = ev_count;
      for (int f = 0; f < 6; f++) begin
         pressed = pattern[f] ? 16'h0200 : 16'h0000;
         wait_clocks(FRAME);
      end
      checks++;
      if (ev_count != ev0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
         failures++; $display("[TB] FAIL bounce_reject: got events=%0d v=%b h=%b required 0 0 0", ev_count - ev0, key_valid, key_held);
      end
      pressed = 16'h0200;
      wait_valid(60, waited);
      checks++;
      if (waited != 48) begin failures++; $display("[TB] FAIL bounce_latency: got %0d required 48", waited); end
      checks++;
      if (key_code !== 4'd9) begin failures++; $display("[TB] FAIL bounce_code: got %0d required 9", key_code); end
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      checks++;
      if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL bounce_ack: got %b required 0", key_valid); end
      pressed = '0;
      wait_clocks(4 * FRAME);
      checks++;
      if (key_held !== 1'b0) begin failures++; $display("[TB] FAIL bounce_release: got %b required 0", key_held); end
   endtask

   task automatic test_ghost;
      int waited, ev0;
      sync_frame;
      ev0 = ev_count;
      pressed = 16'h0011;
      wait_clocks(10 * FRAME);
      checks++;
      if (ev_count != ev0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
         failures++; $display("[TB] FAIL ghost_reject: got events=%0d v=%b h=%b required 0 0 0", ev_count - ev0, key_valid, key_held);
      end
      pressed = 16'h0001;
      wait_valid(60, waited);
      checks++;
      if (waited != 48) begin failures++; $display("[TB] FAIL ghost_latency: got %0d required 48", waited); end
      checks++;
      if (key_code !== 4'd0 || key_held !== 1'b1) begin
         failures++; $display("[TB] FAIL ghost_code: got code=%0d held=%b required 0 1", key_code, key_held);
      end
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      pressed = '0;
      wait_clocks(4 * FRAME);
      checks++;
      if (key_held !== 1'b0 || key_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL ghost_release: got held=%b valid=%b required 0 0", key_held, key_valid);
      end
   endtask

   task automatic test_overrun;
      int waited, ovr0;
      sync_frame;
      ovr0 = ovr_count;
      pressed = 16'h8000;
      wait_valid(60, waited);
      checks++;
      if (waited != 48 || key_code !== 4'd15) begin
         failures++; $display("[TB] FAIL overrun_first: got wait=%0d code=%0d required 48 15", waited, key_code);
      end
      pressed = '0;
      wait_clocks(48);
      checks++;
      if (key_held !== 1'b0 || key_valid !== 1'b1) begin
         failures++; $display("[TB] FAIL overrun_pending: got held=%b valid=%b required 0 1", key_held, key_valid);
      end
      pressed = 16'h0004;
      wait_clocks(47);
      checks++;
      if (ovr_count != ovr0) begin failures++; $display("[TB] FAIL overrun_early: got %0d pulses required 0", ovr_count - ovr0); end
      wait_clocks(1);
      checks++;
      if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_pulse: got %b required 1", overrun); end
      checks++;
      if (key_code !== 4'd15 || key_valid !== 1'b1) begin
         failures++; $display("[TB] FAIL overrun_retain: got code=%0d valid=%b required 15 1", key_code, key_valid);
      end
      wait_clocks(1);
      checks++;
      if (overrun !== 1'b0 || ovr_count != ovr0 + 1) begin
         failures++; $display("[TB] FAIL overrun_single: got o=%b pulses=%0d required 0 1", overrun, ovr_count - ovr0);
      end
      pressed = '0;
      wait_clocks(47);
      checks++;
      if (key_held !== 1'b0) begin failures++; $display("[TB] FAIL overrun_release: got %b required 0", key_held); end
      // Replace the still-pending event by acking on the very edge of the new emit.
      pressed = 16'h0080;
      wait_clocks(47);
      key_ack = 1'b1;
      wait_clocks(1);
      key_ack = 1'b0;
      checks++;
      if (key_code !== 4'd7 || key_valid !== 1'b1 || overrun !== 1'b0) begin
         failures++; $display("[TB] FAIL ack_emit_same_cycle: got code=%0d v=%b o=%b required 7 1 0", key_code, key_valid, overrun);
      end
      wait_clocks(1);
      checks++;
      if (key_valid !== 1'b1) begin failures++; $display("[TB] FAIL ack_emit_hold: got %b required 1", key_valid); end
      key_ack = 1'b1;
      wait_clocks(1);
      checks++;
      if (key_valid !== 1'b0) begin failures++; $display("[TB] FAIL ack_clear: got %b required 0", key_valid); end
      wait_clocks(1);
      key_ack = 1'b0;
      checks++;
      if (key_valid !== 1'b0 || key_code !== 4'd7) begin
         failures++; $display("[TB] FAIL ack_idle_ignored: got v=%b code=%0d required 0 7", key_valid, key_code);
      end
      pressed = '0;
      wait_clocks(4 * FRAME);
   endtask

   task automatic test_hold;
      int nev, exp_n, exp_t;
      logic pv;
`ifdef KEYPAD_REPEAT_EN
      exp_n = 5;
`else
      exp_n = 1;
`endif
      sync_frame;
      pressed = 16'h0040;
      nev = 0;
      pv = 1'b0;
      for (int t = 1; t <= 20 * FRAME; t++) begin
         @(negedge clk);
         if (key_valid === 1'b1 && !pv) begin
            nev++;
            exp_t = 48 + 64 * (nev - 1);
            checks++;
            if (t != exp_t) begin failures++; $display("[TB] FAIL hold_event_time[%0d]: got %0d required %0d", nev, t, exp_t); end
            checks++;
            if (key_code !== 4'd6) begin failures++; $display("[TB] FAIL hold_event_code[%0d]: got %0d required 6", nev, key_code); end
         end
         pv = key_valid;
         key_ack = key_valid;
      end
      key_ack = 1'b0;
      checks++;
      if (nev != exp_n) begin failures++; $display("[TB] FAIL hold_event_count: got %0d required %0d", nev, exp_n); end
      pressed = '0;
      wait_clocks(4 * FRAME);
      checks++;
      if (key_held !== 1'b0) begin failures++; $display("[TB] FAIL hold_release: got %b required 0", key_held); end
   endtask

   task automatic test_reset_midframe;
      int waited, ovr0, ev0;
      sync_frame;
      pressed = 16'h0200;
      wait_valid(60, waited);
      checks++;
      if (waited != 48 || key_valid !== 1'b1) begin
         failures++; $display("[TB] FAIL midreset_setup: got wait=%0d v=%b required 48 1", waited, key_valid);
      end
      wait_clocks(5);
      ovr0 = ovr_count;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (col !== 4'hF || {key_code, key_valid, key_held, overrun} !== 7'd0) begin
         failures++; $display("[TB] FAIL midreset_async: got col=%b code=%0d v=%b h=%b o=%b required 1111 0 0 0 0", col, key_code, key_valid, key_held, overrun);
      end
      pressed = '0;
      wait_clocks(3);
      rst = 1'b0;
      ev0 = ev_count;
      wait_clocks(1);
      checks++;
      if (col !== 4'b1110) begin failures++; $display("[TB] FAIL midreset_restart_col: got %b required 1110", col); end
      wait_clocks(4 * FRAME);
      checks++;
      if (ovr_count != ovr0 || ev_count != ev0 || key_held !== 1'b0) begin
         failures++; $display("[TB] FAIL midreset_quiet: got pulses=%0d events=%0d h=%b required 0 0 0", ovr_count - ovr0, ev_count - ev0, key_held);
      end
   endtask

   initial begin
      test_reset;
      test_clean_press;
      test_bounce;
      test_ghost;
      test_overrun;
      test_hold;
      test_reset_midframe;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
